// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 definitions: data types, sync byte, FSM states, header ECC and payload CRC.
package mipi_csi_pkg;

    localparam logic [7:0] DT_FS     = 8'h00;
    localparam logic [7:0] DT_FE     = 8'h01;
    localparam logic [7:0] DT_RAW8   = 8'h2A;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StHdrA,
        StHdrB,
        StPayload,
        StFooter,
        StGap
    } csi_state_e;

    typedef enum logic [1:0] {
        KindFs,
        KindLine,
        KindFe
    } pkt_kind_e;

    // CSI-2 6-bit Hamming parity over {WC[15:0], DI[7:0]}.
    function automatic logic [5:0] csi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // One byte of CRC-16 (poly 0x8408 reflected), bits consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_csi_transmitter_crc16.sv
// Two-byte-per-cycle CRC-16 accumulator for line payloads.
module csi_crc16
    import mipi_csi_pkg::*;
(
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_lo,
    input  logic [7:0]  data_hi,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Seed on init; otherwise fold lane0 byte then lane1 byte when enabled.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = 16'hFFFF;
        end else if (en) begin
            crc_d = crc16_byte(crc16_byte(crc_q, data_lo), data_hi);
        end
    end

    // CRC state register.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mipi_csi_transmitter.sv
// 2-lane CSI-2 byte-level transmitter: frames a pixel stream into FS, line and FE packets.
module mipi_csi_transmitter
    import mipi_csi_pkg::*;
#(
    parameter int unsigned LINE_BYTES = 1280,
    parameter int unsigned LINES      = 480,
    parameter logic [7:0]  DATA_TYPE  = 8'h2A,
    parameter logic [1:0]  VC         = 2'd0,
    parameter int unsigned GAP        = 8
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  lane0_byte,
    output logic [7:0]  lane1_byte,
    output logic        hs_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int unsigned BEATS  = LINE_BYTES / 2;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP - 1);

    csi_state_e        state_q, state_d;
    pkt_kind_e         kind_q, kind_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [15:0]       frame_q, frame_d;

    logic [7:0]  lane0_d, lane1_d;
    logic        hs_valid_d, pix_ready_d, busy_d, frame_done_d, underrun_d;

    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  ecc;
    logic [7:0]  pay_lo, pay_hi;
    logic [15:0] crc;

    // FSM and bookkeeping registers.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            state_q <= StIdle;
            kind_q  <= KindFs;
            beat_q  <= '0;
            line_q  <= '0;
            gap_q   <= '0;
            frame_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
        end
    end

    // Next-state: packet walk FS -> LINES x line -> FE -> idle.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        beat_d  = beat_q;
        line_d  = line_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSync;
                    kind_d  = KindFs;
                    beat_d  = '0;
                    line_d  = '0;
                    gap_d   = '0;
                    // Frame number 0 is reserved, so wrap skips it.
                    frame_d = (frame_q == 16'hFFFF) ? 16'h0001 : frame_q + 16'd1;
                end
            end
            StSync:  state_d = StHdrA;
            StHdrA:  state_d = StHdrB;
            StHdrB: begin
                beat_d  = '0;
                gap_d   = '0;
                state_d = (kind_q == KindLine) ? StPayload : StGap;
            end
            StPayload: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = StFooter;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StFooter: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == LAST_GAP) begin
                    case (kind_q)
                        KindFs: begin
                            kind_d  = KindLine;
                            line_d  = '0;
                            state_d = StSync;
                        end
                        KindLine: begin
                            state_d = StSync;
                            if (line_q == LAST_LINE) begin
                                kind_d = KindFe;
                            end else begin
                                line_d = line_q + 1'b1;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Header fields for the packet about to be on the lanes.
    always_comb begin
        case (kind_d)
            KindLine: begin
                di = {VC, DATA_TYPE[5:0]};
                wc = 16'(LINE_BYTES);
            end
            KindFe: begin
                di = {VC, DT_FE[5:0]};
                wc = frame_d;
            end
            default: begin
                di = {VC, DT_FS[5:0]};
                wc = frame_d;
            end
        endcase
        ecc    = {2'b00, csi_ecc({wc, di})};
        // Missing pixels are zero-filled so the burst never stalls.
        pay_lo = pix_valid ? pix_data[7:0]  : 8'h00;
        pay_hi = pix_valid ? pix_data[15:8] : 8'h00;
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    always_comb begin
        lane0_d      = 8'h00;
        lane1_d      = 8'h00;
        hs_valid_d   = 1'b0;
        pix_ready_d  = 1'b0;
        busy_d       = (state_d != StIdle);
        frame_done_d = 1'b0;
        underrun_d   = underrun;
        if (state_q == StIdle && start) begin
            underrun_d = 1'b0;
        end
        case (state_d)
            StSync: begin
                lane0_d    = SYNC_BYTE;
                lane1_d    = SYNC_BYTE;
                hs_valid_d = 1'b1;
            end
            StHdrA: begin
                lane0_d    = di;
                lane1_d    = wc[7:0];
                hs_valid_d = 1'b1;
            end
            StHdrB: begin
                lane0_d      = wc[15:8];
                lane1_d      = ecc;
                hs_valid_d   = 1'b1;
                frame_done_d = (kind_d == KindFe);
                // Ready runs one cycle ahead: data taken now is on the lanes next cycle.
                pix_ready_d  = (kind_d == KindLine);
            end
            StPayload: begin
                lane0_d     = pay_lo;
                lane1_d     = pay_hi;
                hs_valid_d  = 1'b1;
                pix_ready_d = (beat_d != LAST_BEAT);
                if (!pix_valid) begin
                    underrun_d = 1'b1;
                end
            end
            StFooter: begin
                lane0_d    = crc[7:0];
                lane1_d    = crc[15:8];
                hs_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge byte_clk) begin
        if (reset) begin
            lane0_byte <= 8'h00;
            lane1_byte <= 8'h00;
            hs_valid   <= 1'b0;
            pix_ready  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            lane0_byte <= lane0_d;
            lane1_byte <= lane1_d;
            hs_valid   <= hs_valid_d;
            pix_ready  <= pix_ready_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
        end
    end

    csi_crc16 u_crc (
        .byte_clk (byte_clk),
        .reset    (reset),
        .init     (state_d == StSync),
        .en       (state_d == StPayload),
        .data_lo  (pay_lo),
        .data_hi  (pay_hi),
        .crc      (crc)
    );

endmodule
